// File: rtl/carbon_z90_pkg.sv
// CarbonZ90 shared types: boot program ROM, sequencer states and MMIO constants.
// The optional readback check is enabled by defining CARBONZ90_READBACK_VERIFY_EN.
package carbon_z90_pkg;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } rom_entry_t;

  typedef enum logic [2:0] {BOOT, FETCH, WRITE, VERIFY, GAP, DONE, ERROR} seq_state_t;

  localparam logic [7:0]  SIG_BASE      = 8'h00;
  localparam logic [7:0]  PWROFF_ADDR   = 8'h04;
  localparam int          PROG_LEN      = 5;
  localparam logic [31:0] EXP_SIGNATURE = 32'h2130_395A;

  localparam rom_entry_t PROG_ROM [PROG_LEN] = '{
    '{addr: 8'h00, data: 8'h5A},
    '{addr: 8'h01, data: 8'h39},
    '{addr: 8'h02, data: 8'h30},
    '{addr: 8'h03, data: 8'h21},
    '{addr: 8'h04, data: 8'h01}
  };

endpackage

// File: rtl/carbon_z90_sysctl.sv
// System-control MMIO device: byte-wise signature register and sticky poweroff.
// With CARBONZ90_READBACK_VERIFY_EN it adds a combinational read port and an error override.
module carbon_z90_sysctl
  import carbon_z90_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_addr,
  input  logic [7:0]  i_wr_data,
`ifdef CARBONZ90_READBACK_VERIFY_EN
  input  logic [7:0]  i_rd_addr,
  output logic [7:0]  o_rd_data,
  input  logic        i_error,
`endif
  output logic [31:0] o_signature,
  output logic        o_poweroff
);

  logic [3:0][7:0] r_sig;
  logic            r_poweroff;

  // Signature bytes freeze once poweroff has been requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig      <= '0;
      r_poweroff <= 1'b0;
    end else if (i_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!r_poweroff && i_wr_addr == SIG_BASE + 8'(i)) r_sig[i] <= i_wr_data;
      end
      if (i_wr_addr == PWROFF_ADDR && i_wr_data[0]) r_poweroff <= 1'b1;
    end
  end

`ifdef CARBONZ90_READBACK_VERIFY_EN
  always_comb begin
    o_rd_data = 8'h00;
    if (i_rd_addr == PWROFF_ADDR) o_rd_data = {7'b0, r_poweroff};
    else if (i_rd_addr < SIG_BASE + 8'd4) o_rd_data = r_sig[i_rd_addr[1:0]];
  end

  assign o_signature = i_error ? {8'hEE, r_sig[2], r_sig[1], r_sig[0]} : r_sig;
  assign o_poweroff  = r_poweroff & ~i_error;
`else
  assign o_signature = r_sig;
  assign o_poweroff  = r_poweroff;
`endif

endmodule

// File: rtl/carbon_z90_top.sv
// CarbonZ90 top: boot sequencer replaying the program ROM as MMIO writes into sysctl.
// Define CARBONZ90_READBACK_VERIFY_EN to add a readback VERIFY step and terminal ERROR state.
module carbon_z90_top
  import carbon_z90_pkg::*;
#(
  parameter int BOOT_DELAY = 2,
  parameter int STEP_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] signature,
  output logic        poweroff
);

  seq_state_t r_state, w_state_next;
  logic [2:0]  r_pc, w_pc_next;
  logic [15:0] r_cnt, w_cnt_next;
  rom_entry_t  r_entry, w_entry_next;
  logic        w_wr_en;
`ifdef CARBONZ90_READBACK_VERIFY_EN
  logic [7:0]  w_rd_data;
  logic        w_error;
`endif

  // With no gap configured, a finished step goes straight to the next fetch.
  function automatic seq_state_t step_exit(input logic [2:0] pc);
    if (STEP_WAIT != 0) return GAP;
    return (pc < 3'(PROG_LEN)) ? FETCH : DONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_entry <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
      r_entry <= w_entry_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    w_entry_next = r_entry;
    w_wr_en      = 1'b0;
    case (r_state)
      BOOT: begin
        if (r_cnt >= 16'(BOOT_DELAY)) begin
          w_state_next = FETCH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      FETCH: begin
        w_entry_next = PROG_ROM[r_pc];
        w_state_next = WRITE;
      end
      WRITE: begin
        w_wr_en    = 1'b1;
        w_pc_next  = r_pc + 3'd1;
        w_cnt_next = 16'd1;
`ifdef CARBONZ90_READBACK_VERIFY_EN
        w_state_next = VERIFY;
`else
        w_state_next = step_exit(r_pc + 3'd1);
`endif
      end
`ifdef CARBONZ90_READBACK_VERIFY_EN
      VERIFY: begin
        w_cnt_next = 16'd1;
        if (w_rd_data != r_entry.data) w_state_next = ERROR;
        else                           w_state_next = step_exit(r_pc);
      end
`endif
      GAP: begin
        if (r_cnt >= 16'(STEP_WAIT)) begin
          w_state_next = (r_pc < 3'(PROG_LEN)) ? FETCH : DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

`ifdef CARBONZ90_READBACK_VERIFY_EN
  assign w_error = (r_state == ERROR);
`endif

  carbon_z90_sysctl u_sysctl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (r_entry.addr),
    .i_wr_data   (r_entry.data),
`ifdef CARBONZ90_READBACK_VERIFY_EN
    .i_rd_addr   (r_entry.addr),
    .o_rd_data   (w_rd_data),
    .i_error     (w_error),
`endif
    .o_signature (signature),
    .o_poweroff  (poweroff)
  );

endmodule

// File: tb/tb_carbon_z90_top.sv
// Scoreboard bench for carbon_z90_top: two instances (default timing and zero delays), randomized reset runs.
module tb_carbon_z90_top;

  typedef struct {
    int          cyc;
    logic [31:0] sig;
    logic        pwr;
  } ev_t;

  localparam int N = 2;
  localparam logic [31:0] GOLD = 32'h2130_395A;
`ifdef CARBONZ90_READBACK_VERIFY_EN
  localparam int STEP_BASE = 3;
`else
  localparam int STEP_BASE = 2;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] sig [N];
  logic        pwr [N];
  logic [31:0] prev_sig [N];
  logic        prev_pwr [N];
  ev_t         exp_q [N][$];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  carbon_z90_top #(.BOOT_DELAY(2), .STEP_WAIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .signature(sig[0]), .poweroff(pwr[0]));
  carbon_z90_top #(.BOOT_DELAY(0), .STEP_WAIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .signature(sig[1]), .poweroff(pwr[1]));

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference timing: boot takes 1+BOOT_DELAY cycles, each step FETCH+WRITE(+VERIFY)+gap.
  function automatic int write_cycle(input int i, input int k);
    int bd;
    int sw;
    bd = (i == 0) ? 2 : 0;
    sw = (i == 0) ? 4 : 0;
    return bd + 3 + k * (STEP_BASE + sw);
  endfunction

  task automatic load_expect();
    logic [31:0] gold;
    logic [31:0] s;
    ev_t         e;
    gold = GOLD;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      s = 32'h0;
      for (int k = 0; k < 5; k++) begin
        if (k < 4) s[8*k +: 8] = gold[8*k +: 8];
        e.cyc = write_cycle(i, k);
        e.sig = s;
        e.pwr = (k == 4);
        exp_q[i].push_back(e);
      end
    end
  endtask

  // Monitor: every visible output change must be the next expected event, on its cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        prev_sig[i] = 32'h0;
        prev_pwr[i] = 1'b0;
      end else if (sig[i] !== prev_sig[i] || pwr[i] !== prev_pwr[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_change dut%0d cyc %0d: got sig=%h pwr=%b, required no change (sig=%h pwr=%b)",
                   i, cyc, sig[i], pwr[i], prev_sig[i], prev_pwr[i]);
        end else begin
          ev_t e;
          e = exp_q[i].pop_front();
          if (e.cyc != cyc || e.sig !== sig[i] || e.pwr !== pwr[i]) begin
            errors++;
            $display("FAIL event dut%0d: got cyc=%0d sig=%h pwr=%b, required cyc=%0d sig=%h pwr=%b",
                     i, cyc, sig[i], pwr[i], e.cyc, e.sig, e.pwr);
          end else begin
            $display("dut%0d cyc %0d sig=%h pwr=%b ok", i, cyc, sig[i], pwr[i]);
          end
        end
        prev_sig[i] = sig[i];
        prev_pwr[i] = pwr[i];
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sig[i] !== 32'h0 || pwr[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_%s dut%0d: got sig=%h pwr=%b, required sig=00000000 pwr=0",
                 tag, i, sig[i], pwr[i]);
      end else begin
        $display("reset_%s dut%0d sig=%h pwr=%b ok", tag, i, sig[i], pwr[i]);
      end
    end
  endtask

  task automatic run_program(input int len);
    int missed;
    @(negedge clk);
    #2;
    load_expect();
    rst_n = 1'b1;
    repeat (len) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      missed = 0;
      foreach (exp_q[i][j]) if (exp_q[i][j].cyc <= len) missed++;
      checks++;
      if (missed != 0) begin
        errors++;
        $display("FAIL missed_events dut%0d after %0d cycles: got %0d pending, required 0", i, len, missed);
      end
      if (len >= write_cycle(i, 4)) begin
        checks++;
        if (sig[i] !== GOLD || pwr[i] !== 1'b1) begin
          errors++;
          $display("FAIL final dut%0d after %0d cycles: got sig=%h pwr=%b, required sig=%h pwr=1",
                   i, len, sig[i], pwr[i], GOLD);
        end else begin
          $display("final dut%0d after %0d cycles sig=%h pwr=1 ok", i, len, sig[i]);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    check_reset("assert");
    repeat (int'($urandom_range(1, 4))) @(posedge clk);
  endtask

  initial begin
    int len;
    #1 rst_n = 1'b0;
    #1;
    check_reset("power_on");
    for (int run = 0; run < 14; run++) begin
      if (run == 0 || run == 7)      len = write_cycle(0, 4) + 1000;
      else if (run == 1)             len = write_cycle(0, 2) + 1;
      else if (run == 2)             len = write_cycle(0, 1) + 1;
      else                           len = int'($urandom_range(1, 45));
      run_program(len);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
